// File: rtl/camera_stream_packer.sv
// rtl/camera_stream_packer.sv - camera pixel capture, beat packing and Avalon-ST source with output FIFO
// Optional: CAM_PACK_TESTPATTERN_EN substitutes a {line, pixel} counter pattern for cam_d.
module camera_stream_packer #(
    parameter int PIX_W           = 12,
    parameter int PIXELS_PER_BEAT = 4,
    parameter int FIFO_DEPTH      = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [PIX_W-1:0]                 cam_d,
    input  logic                             cam_fval,
    input  logic                             cam_lval,
    input  logic                             capture_en,
    input  logic                             single_shot,
    output logic [PIX_W*PIXELS_PER_BEAT-1:0] src_data,
    output logic                             src_valid,
    input  logic                             src_ready,
    output logic                             src_sop,
    output logic                             src_eop,
    output logic                             busy,
    output logic                             frame_done,
    output logic                             frame_ok,
    output logic [15:0]                      line_width,
    output logic [15:0]                      frame_height,
    output logic                             overflow
);
    localparam int DW = PIX_W * PIXELS_PER_BEAT;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int IW = (PIXELS_PER_BEAT > 1) ? $clog2(PIXELS_PER_BEAT) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(PIXELS_PER_BEAT - 1);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_WAIT_SOF, S_CAPTURE, S_DROP, S_DONE} state_t;
    state_t state_q, state_d;

    logic fval_q, fval_d, fval_p_q, fval_p_d, lval_q, lval_d, lval_p_q, lval_p_d;
    logic cap_q, cap_d, cap_p_q, cap_p_d, ss_q, ss_d;
    logic [DW-1:0] pack_q, pack_d, pk, beat_data;
    logic [IW-1:0] pidx_q, pidx_d, ix;
    logic first_q, first_d, first_eff, had_pix_q, had_pix_d;
    logic [DW-1:0] stg_data_q, stg_data_d;
    logic stg_vld_q, stg_vld_d, stg_sop_q, stg_sop_d, stg_eop_q, stg_eop_d;
    logic [15:0] pix_cnt_q, pix_cnt_d, line_cnt_q, line_cnt_d;
    logic [15:0] line_width_q, line_width_d, frame_height_q, frame_height_d;
    logic overflow_q, overflow_d, frame_ok_q, frame_ok_d;
    logic [AW:0] wr_q, wr_d, rd_q, rd_d;
    logic [DW+1:0] mem_q [FIFO_DEPTH];
    logic [DW+1:0] push_word;
    logic [PIX_W-1:0] pix_val;
    logic fval_rise, fval_fall, lval_rise, lval_fall, pix_vld, sof, cap_act, in_frame, pix_take;
    logic beat_done, push, pop, empty, full, can_push, ovf_evt;

    assign fval_rise = fval_q & ~fval_p_q;
    assign fval_fall = ~fval_q & fval_p_q;
    assign lval_rise = lval_q & ~lval_p_q;
    assign lval_fall = ~lval_q & lval_p_q;
    assign pix_vld   = fval_q & lval_q;
    assign sof       = (state_q == S_WAIT_SOF) & fval_rise;
    assign cap_act   = (state_q == S_CAPTURE) | sof;
    assign in_frame  = (state_q == S_CAPTURE) | (state_q == S_DROP);
    assign pix_take  = cap_act & pix_vld;

`ifdef CAM_PACK_TESTPATTERN_EN
    logic [3:0] line_idx_q, line_idx_d;
    logic [7:0] pattern;
    assign pattern = {line_idx_q, pix_cnt_q[3:0]};
    assign pix_val = PIX_W'(pattern);
    always_comb begin
        line_idx_d = line_idx_q;
        if (fval_rise)
            line_idx_d = '0;
        else if (lval_fall)
            line_idx_d = line_idx_q + 4'd1;
    end
    always_ff @(posedge clk) begin
        if (reset) line_idx_q <= '0;
        else       line_idx_q <= line_idx_d;
    end
`else
    logic [PIX_W-1:0] d_q, d_d;
    assign pix_val = d_q;
    always_comb d_d = cam_d;
    always_ff @(posedge clk) begin
        if (reset) d_q <= '0;
        else       d_q <= d_d;
    end
`endif

    // FIFO occupancy: pointers carry one extra wrap bit
    assign empty    = (wr_q == rd_q);
    assign full     = ((wr_q - rd_q) == FULL_CNT);
    assign pop      = ~empty & src_ready;
    assign can_push = ~full | pop;

    always_comb begin
        fval_d   = cam_fval;
        lval_d   = cam_lval;
        cap_d    = capture_en;
        ss_d     = single_shot;
        fval_p_d = fval_q;
        lval_p_d = lval_q;
        cap_p_d  = cap_q;

        pix_cnt_d = pix_cnt_q;
        if (lval_fall)
            pix_cnt_d = '0;
        else if (pix_vld && pix_cnt_q != 16'hFFFF)
            pix_cnt_d = pix_cnt_q + 16'd1;
        line_width_d = lval_fall ? pix_cnt_q : line_width_q;

        line_cnt_d = line_cnt_q;
        if (fval_rise)
            line_cnt_d = lval_rise ? 16'd1 : 16'd0;
        else if (fval_fall)
            line_cnt_d = '0;
        else if (lval_rise && fval_q && line_cnt_q != 16'hFFFF)
            line_cnt_d = line_cnt_q + 16'd1;
        frame_height_d = fval_fall ? line_cnt_q : frame_height_q;
    end

    always_comb begin
        pk        = sof ? '0 : pack_q;
        ix        = sof ? '0 : pidx_q;
        beat_done = 1'b0;
        beat_data = '0;
        if (pix_take) begin
            pk[int'(ix)*PIX_W +: PIX_W] = pix_val;
            if (ix == LAST_IDX) begin
                beat_done = 1'b1;
                beat_data = pk;
                pk        = '0;
                ix        = '0;
            end else begin
                ix = ix + 1'b1;
            end
        end else if (state_q == S_CAPTURE && lval_fall && ix != '0) begin
            beat_done = 1'b1;
            beat_data = pk;
            pk        = '0;
            ix        = '0;
        end
        pack_d = pk;
        pidx_d = ix;

        // Staged beat leaves only once its successor exists or the frame has ended
        first_eff  = sof | first_q;
        first_d    = first_eff;
        stg_data_d = stg_data_q;
        stg_vld_d  = stg_vld_q;
        stg_sop_d  = stg_sop_q;
        stg_eop_d  = stg_eop_q;
        push       = 1'b0;
        push_word  = '0;
        ovf_evt    = 1'b0;
        if (beat_done) begin
            if (stg_vld_q && !can_push) begin
                ovf_evt   = 1'b1;
                stg_eop_d = 1'b1;
            end else begin
                push       = stg_vld_q;
                push_word  = {stg_sop_q, stg_eop_q, stg_data_q};
                stg_data_d = beat_data;
                stg_vld_d  = 1'b1;
                stg_sop_d  = first_eff;
                stg_eop_d  = 1'b0;
                first_d    = 1'b0;
            end
        end else if (stg_vld_q && stg_eop_q && can_push) begin
            push      = 1'b1;
            push_word = {stg_sop_q, stg_eop_q, stg_data_q};
            stg_vld_d = 1'b0;
            stg_sop_d = 1'b0;
            stg_eop_d = 1'b0;
        end
        if (in_frame && fval_fall && stg_vld_d)
            stg_eop_d = 1'b1;

        wr_d = wr_q + {{AW{1'b0}}, push};
        rd_d = rd_q + {{AW{1'b0}}, pop};

        had_pix_d = sof ? pix_take : (had_pix_q | pix_take);
        overflow_d = (sof ? 1'b0 : overflow_q) | ovf_evt;
        frame_ok_d = (state_q == S_DONE) ? (~overflow_q & had_pix_q) : frame_ok_q;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (cap_q && (!ss_q || !cap_p_q)) state_d = S_WAIT_SOF;
            S_WAIT_SOF: if (fval_rise) state_d = S_CAPTURE;
                        else if (!cap_q) state_d = S_IDLE;
            S_CAPTURE:  if (fval_fall) state_d = S_DONE;
                        else if (ovf_evt) state_d = S_DROP;
            S_DROP:     if (fval_fall) state_d = S_DONE;
            S_DONE:     state_d = (cap_q && !ss_q) ? S_WAIT_SOF : S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            fval_q         <= 1'b0;
            lval_q         <= 1'b0;
            fval_p_q       <= 1'b0;
            lval_p_q       <= 1'b0;
            cap_q          <= 1'b0;
            cap_p_q        <= 1'b0;
            ss_q           <= 1'b0;
            pack_q         <= '0;
            pidx_q         <= '0;
            first_q        <= 1'b0;
            had_pix_q      <= 1'b0;
            stg_data_q     <= '0;
            stg_vld_q      <= 1'b0;
            stg_sop_q      <= 1'b0;
            stg_eop_q      <= 1'b0;
            pix_cnt_q      <= '0;
            line_cnt_q     <= '0;
            line_width_q   <= '0;
            frame_height_q <= '0;
            overflow_q     <= 1'b0;
            frame_ok_q     <= 1'b0;
            wr_q           <= '0;
            rd_q           <= '0;
        end else begin
            state_q        <= state_d;
            fval_q         <= fval_d;
            lval_q         <= lval_d;
            fval_p_q       <= fval_p_d;
            lval_p_q       <= lval_p_d;
            cap_q          <= cap_d;
            cap_p_q        <= cap_p_d;
            ss_q           <= ss_d;
            pack_q         <= pack_d;
            pidx_q         <= pidx_d;
            first_q        <= first_d;
            had_pix_q      <= had_pix_d;
            stg_data_q     <= stg_data_d;
            stg_vld_q      <= stg_vld_d;
            stg_sop_q      <= stg_sop_d;
            stg_eop_q      <= stg_eop_d;
            pix_cnt_q      <= pix_cnt_d;
            line_cnt_q     <= line_cnt_d;
            line_width_q   <= line_width_d;
            frame_height_q <= frame_height_d;
            overflow_q     <= overflow_d;
            frame_ok_q     <= frame_ok_d;
            wr_q           <= wr_d;
            rd_q           <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_q[AW-1:0]] <= push_word;
    end

    assign src_valid = ~empty;
    assign {src_sop, src_eop, src_data} = empty ? '0 : mem_q[rd_q[AW-1:0]];
    assign busy         = (state_q != S_IDLE);
    assign frame_done   = (state_q == S_DONE);
    assign frame_ok     = frame_ok_q;
    assign line_width   = line_width_q;
    assign frame_height = frame_height_q;
    assign overflow     = overflow_q;
endmodule
